// File: rtl/sky130_fd_io__lvc_pkg.sv
// sky130_fd_io__lvc_pkg: shared state encoding, default timing constants and timer sizing
// for the low-voltage clamp sequencer.
package sky130_fd_io__lvc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_CLAMP,
        ST_HOLD,
        ST_COOLDOWN
    } lvc_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYC     = 4;
    localparam int DEF_MIN_ON_CYC  = 16;
    localparam int DEF_COOL_CYC    = 8;
    localparam int DEF_CNT_W       = 8;

    // The shared down-timer only ever holds (max period - 1), so clog2(max) bits suffice.
    function automatic int tmr_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sky130_fd_io__lvc_sync.sv
// sky130_fd_io__lvc_sync: STAGES-deep single-bit synchronizer, flops reset to 0.
module sky130_fd_io__lvc_sync
    import sky130_fd_io__lvc_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sky130_fd_io__lvc_clamp_seq.sv
// sky130_fd_io__lvc_clamp_seq: debounce / min-on / hold / cooldown sequencer for the clamp gate.
// Optional event counter enabled by defining SKY130_FD_IO_LVC_EVT_CNT_EN.
module sky130_fd_io__lvc_clamp_seq
    import sky130_fd_io__lvc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYC     = DEF_DEB_CYC,
    parameter int MIN_ON_CYC  = DEF_MIN_ON_CYC,
    parameter int COOL_CYC    = DEF_COOL_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             trig_async,
    input  logic             force_req,
    output logic             force_ack,
    output logic             ogc_lvc_en,
    output logic             busy,
    input  logic             evt_clr,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int TW = tmr_w(DEB_CYC, MIN_ON_CYC, COOL_CYC);
    localparam logic [TW-1:0] DEB_LD  = TW'(DEB_CYC - 1);
    localparam logic [TW-1:0] ON_LD   = TW'(MIN_ON_CYC - 1);
    localparam logic [TW-1:0] COOL_LD = TW'(COOL_CYC - 1);

    lvc_state_e    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          ogc_q, ogc_d;
    logic          ack_q, ack_d;
    logic          trig_s, trig_ok, hold_ok;

    sky130_fd_io__lvc_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (trig_async),
        .q   (trig_s)
    );

    // Timer reaching zero marks the last cycle of the current phase.
    always_comb begin
        trig_ok = trig_s && enable;
        hold_ok = trig_ok || force_req;
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (force_req) begin
                    state_d = ST_CLAMP;
                    tmr_d   = ON_LD;
                end else if (trig_ok) begin
                    state_d = ST_DEBOUNCE;
                    tmr_d   = DEB_LD;
                end
            end
            ST_DEBOUNCE: begin
                if (force_req || tmr_q == '0) begin
                    state_d = ST_CLAMP;
                    tmr_d   = ON_LD;
                end else if (!trig_ok) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_CLAMP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    state_d = hold_ok ? ST_HOLD : ST_COOLDOWN;
                    tmr_d   = hold_ok ? '0 : COOL_LD;
                end
            end
            ST_HOLD: begin
                state_d = hold_ok ? ST_HOLD : ST_COOLDOWN;
                tmr_d   = hold_ok ? '0 : COOL_LD;
            end
            ST_COOLDOWN: begin
                state_d = (tmr_q == '0) ? ST_IDLE : ST_COOLDOWN;
                tmr_d   = (tmr_q == '0) ? '0 : tmr_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
        ogc_d = (state_d == ST_CLAMP) || (state_d == ST_HOLD);
        ack_d = force_req && ogc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            ogc_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ogc_q   <= ogc_d;
            ack_q   <= ack_d;
        end
    end

    assign ogc_lvc_en = ogc_q;
    assign force_ack  = ack_q;
    assign busy       = state_q != ST_IDLE;

`ifdef SKY130_FD_IO_LVC_EVT_CNT_EN
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             evt_inc;

    // A clear coinciding with a new event still records that event.
    always_comb begin
        evt_inc   = (state_d == ST_CLAMP) && (state_q != ST_CLAMP);
        evt_cnt_d = evt_clr ? CNT_W'(evt_inc)
                  : (evt_inc && !(&evt_cnt_q)) ? evt_cnt_q + 1'b1 : evt_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) evt_cnt_q <= '0;
        else     evt_cnt_q <= evt_cnt_d;
    end

    assign evt_cnt = evt_cnt_q;
`else
    logic unused_evt_clr;
    assign unused_evt_clr = evt_clr;
    assign evt_cnt        = '0;
`endif

endmodule

// File: tb/tb_sky130_fd_io__lvc_clamp_seq.sv
// tb_sky130_fd_io__lvc_clamp_seq: directed scenarios plus random traffic against a
// phase/elapsed-cycle reference model of the clamp sequencer.
module tb_sky130_fd_io__lvc_clamp_seq;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int MINON = 16;
    localparam int COOL  = 8;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef SKY130_FD_IO_LVC_EVT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, enable, trig_async, force_req, evt_clr;
    logic          force_ack, ogc_lvc_en, busy;
    logic [CW-1:0] evt_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sky130_fd_io__lvc_clamp_seq #(
        .SYNC_STAGES (SYNC),
        .DEB_CYC     (DEB),
        .MIN_ON_CYC  (MINON),
        .COOL_CYC    (COOL),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .trig_async (trig_async),
        .force_req  (force_req),
        .force_ack  (force_ack),
        .ogc_lvc_en (ogc_lvc_en),
        .busy       (busy),
        .evt_clr    (evt_clr),
        .evt_cnt    (evt_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: phase 0 idle, 1 debounce, 2 clamp, 3 hold, 4 cooldown;
    // m_n counts elapsed cycles inside the current phase, starting at 1.
    logic [SYNC-1:0] m_syn;
    int m_ph, m_n, m_cnt;
    bit m_ogc, m_ack, m_busy;

    always @(posedge clk) begin
        bit ts, tok, prev, enter;
        if (rst) begin
            m_syn = '0; m_ph = 0; m_n = 0; m_cnt = 0;
            m_ogc = 1'b0; m_ack = 1'b0;
        end else begin
            ts    = m_syn[SYNC-1];
            m_syn = {m_syn[SYNC-2:0], trig_async};
            tok   = ts && enable;
            prev  = m_ogc;
            enter = 1'b0;
            case (m_ph)
                0: if (force_req) enter = 1'b1;
                   else if (tok) begin m_ph = 1; m_n = 1; end
                1: if (force_req || m_n == DEB) enter = 1'b1;
                   else if (!tok) m_ph = 0;
                   else m_n++;
                2: if (m_n < MINON) m_n++;
                   else if (tok || force_req) m_ph = 3;
                   else begin m_ph = 4; m_n = 1; end
                3: if (!(tok || force_req)) begin m_ph = 4; m_n = 1; end
                default: if (m_n < COOL) m_n++; else m_ph = 0;
            endcase
            if (enter) begin m_ph = 2; m_n = 1; end
            m_ogc = (m_ph == 2) || (m_ph == 3);
            m_ack = force_req && prev;
            if (CNT_EN)
                m_cnt = evt_clr ? int'(enter) : enter ? ((m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1) : m_cnt;
        end
        m_busy = m_ph != 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ogc",  32'(ogc_lvc_en), 32'(m_ogc));
            check("model_ack",  32'(force_ack),  32'(m_ack));
            check("model_busy", 32'(busy),       32'(m_busy));
            check("model_cnt",  32'(evt_cnt),    32'(m_cnt));
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; trig_async = 1'b0; force_req = 1'b0; evt_clr = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        check("rst_ogc",  32'(ogc_lvc_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack",  32'(force_ack), 0);
        check("rst_cnt",  32'(evt_cnt), 0);
        rst = 1'b0;
        cyc(2);

        // 1: held trigger clamps on the 7th edge counting the first sampling edge
        trig_async = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check($sformatf("t1_rise_e%0d", k), 32'(ogc_lvc_en), 32'(k >= 7));
        end
        cyc(20);
        trig_async = 1'b0;
        cyc(2);
        check("t1_hold_still_on", 32'(ogc_lvc_en), 1);
        cyc(1);
        check("t1_release", 32'(ogc_lvc_en), 0);
        cyc(7);
        check("t1_cool_busy", 32'(busy), 1);
        cyc(1);
        check("t1_idle", 32'(busy), 0);

        // 2: three synced cycles of trigger never reach the clamp
        trig_async = 1'b1;
        cyc(3);
        trig_async = 1'b0;
        cyc(10);
        check("t2_no_clamp", 32'(ogc_lvc_en), 0);
        check("t2_cnt", 32'(evt_cnt), 0);

        // 3: forced clamp handshake and enforced minimum on-time
        force_req = 1'b1;
        cyc(1);
        check("t3_ogc_next", 32'(ogc_lvc_en), 1);
        check("t3_ack_late", 32'(force_ack), 0);
        cyc(1);
        check("t3_ack", 32'(force_ack), 1);
        force_req = 1'b0;
        cyc(1);
        check("t3_ack_drop", 32'(force_ack), 0);
        cyc(13);
        check("t3_min_on", 32'(ogc_lvc_en), 1);
        cyc(1);
        check("t3_off", 32'(ogc_lvc_en), 0);

        // 4: trigger raised in cooldown is ignored until idle, then debounced afresh
        trig_async = 1'b1; enable = 1'b1;
        cyc(12);
        check("t4_not_yet", 32'(ogc_lvc_en), 0);
        cyc(1);
        check("t4_second", 32'(ogc_lvc_en), 1);
        trig_async = 1'b0;
        cyc(30);

        // 5: reset in the middle of a clamp drops everything at that edge
        force_req = 1'b1;
        cyc(5);
        check("t5_pre_ack", 32'(force_ack), 1);
        rst = 1'b1; force_req = 1'b0;
        cyc(1);
        check("t5_ogc", 32'(ogc_lvc_en), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ack", 32'(force_ack), 0);
        rst = 1'b0;
        cyc(2);

        // 6: saturating event count and clear coinciding with an entry
        for (int i = 1; i <= 5; i++) begin
            force_req = 1'b1;
            cyc(1);
            check($sformatf("t6_cnt_%0d", i), 32'(evt_cnt), CNT_EN ? ((i > MAXC) ? MAXC : i) : 0);
            force_req = 1'b0;
            cyc(30);
        end
        force_req = 1'b1; evt_clr = 1'b1;
        cyc(1);
        check("t6_clr_entry", 32'(evt_cnt), CNT_EN ? 1 : 0);
        force_req = 1'b0; evt_clr = 1'b0;
        cyc(30);

        // random traffic: bursty trigger, mostly-on enable, occasional force/clear/reset
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5) == 0) trig_async = ~trig_async;
            enable    = $urandom_range(7) != 0;
            if ($urandom_range(40) == 0) force_req = ~force_req;
            evt_clr   = $urandom_range(19) == 0;
            rst       = $urandom_range(399) == 0;
            cyc(1);
        end
        rst = 1'b0; force_req = 1'b0; trig_async = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
